// File: rtl/spmv_sram_loader.sv
// Packs a 16-bit CSR word stream into 256-bit SRAM A/B lines (IV, RP, MV, CI phases).
// Define SPMV_LOADER_CHECK_EN to enable the row-pointer monotonicity check on o_error.
//
// state | meaning
// IDLE  | waiting for i_start
// IV    | 16 input-vector words -> A line 0
// RP    | 17 row-pointer bytes  -> B line 0, latch nnz
// MV    | nnz matrix values     -> A lines MV_BASE..
// CI    | nnz column nibbles    -> B lines CI_BASE..
// DONE  | one-cycle o_done
module spmv_sram_loader #(
  parameter int unsigned MV_BASE     = 1,
  parameter int unsigned CI_BASE     = 1,
  parameter int unsigned RESULT_ADDR = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_valid,
  input  logic [15:0]  i_data,
  output logic         o_ready,
  output logic         o_wr_en_A,
  output logic [4:0]   o_address_A,
  output logic [255:0] o_write_data_A,
  output logic         o_wr_en_B,
  output logic [4:0]   o_address_B,
  output logic [255:0] o_write_data_B,
  output logic [2:0]   o_state,
  output logic         o_error,
  output logic         o_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IV   = 3'd1,
    S_RP   = 3'd2,
    S_MV   = 3'd3,
    S_CI   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [4:0] MV_BASE_A  = 5'(MV_BASE);
  localparam logic [4:0] CI_BASE_A  = 5'(CI_BASE);
  localparam logic [4:0] RESULT_A   = 5'(RESULT_ADDR);

  state_t         state_q, state_d;
  logic [7:0]     beat_q, beat_d;
  logic [7:0]     nnz_q, nnz_d;
  logic [255:0]   pack_q, pack_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic           wr_en_a_q, wr_en_a_d;
  logic [4:0]     addr_a_q, addr_a_d;
  logic [255:0]   wdata_a_q, wdata_a_d;
  logic           wr_en_b_q, wr_en_b_d;
  logic [4:0]     addr_b_q, addr_b_d;
  logic [255:0]   wdata_b_q, wdata_b_d;

  logic           accept;
  logic           last_beat;
  logic [255:0]   lane16, lane8, lane4;
  logic [4:0]     ci_addr;

  assign accept    = i_valid && ready_q;
  assign last_beat = (beat_q == nnz_q - 8'd1);
  assign ci_addr   = CI_BASE_A + {3'b000, beat_q[7:6]};

  // Pack lanes are cleared at every hand-off, so OR-ing the shifted word is enough.
  assign lane16 = {240'd0, i_data}      << {beat_q[3:0], 4'b0000};
  assign lane8  = {248'd0, i_data[7:0]} << {beat_q[4:0], 3'b000};
  assign lane4  = {252'd0, i_data[3:0]} << {beat_q[5:0], 2'b00};

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    nnz_d     = nnz_q;
    pack_d    = pack_q;
    done_d    = 1'b0;
    wr_en_a_d = 1'b0;
    addr_a_d  = '0;
    wdata_a_d = '0;
    wr_en_b_d = 1'b0;
    addr_b_d  = '0;
    wdata_b_d = '0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          beat_d  = '0;
          pack_d  = '0;
          state_d = S_IV;
        end
      end

      S_IV: begin
        if (accept) begin
          if (beat_q == 8'd15) begin
            wr_en_a_d = 1'b1;
            addr_a_d  = 5'd0;
            wdata_a_d = pack_q | lane16;
            pack_d    = '0;
            beat_d    = '0;
            state_d   = S_RP;
          end else begin
            pack_d = pack_q | lane16;
            beat_d = beat_q + 8'd1;
          end
        end
      end

      S_RP: begin
        if (accept) begin
          if (beat_q == 8'd16) begin
            wr_en_b_d = 1'b1;
            addr_b_d  = 5'd0;
            wdata_b_d = pack_q | lane8;
            pack_d    = '0;
            beat_d    = '0;
            nnz_d     = i_data[7:0];
            if (i_data[7:0] == 8'd0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_MV;
            end
          end else begin
            pack_d = pack_q | lane8;
            beat_d = beat_q + 8'd1;
          end
        end
      end

      S_MV: begin
        if (accept) begin
          if (beat_q[3:0] == 4'hf || last_beat) begin
            wr_en_a_d = 1'b1;
            addr_a_d  = MV_BASE_A + {1'b0, beat_q[7:4]};
            wdata_a_d = pack_q | lane16;
            pack_d    = '0;
          end else begin
            pack_d = pack_q | lane16;
          end
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_CI;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      S_CI: begin
        if (accept) begin
          if (beat_q[5:0] == 6'h3f || last_beat) begin
            // The result line belongs to the datapath; a misconfigured base must not clobber it.
            wr_en_b_d = (ci_addr != RESULT_A);
            addr_b_d  = ci_addr;
            wdata_b_d = pack_q | lane4;
            pack_d    = '0;
          end else begin
            pack_d = pack_q | lane4;
          end
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IV) || (state_d == S_RP) ||
              (state_d == S_MV) || (state_d == S_CI);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      nnz_q     <= '0;
      pack_q    <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_en_a_q <= 1'b0;
      addr_a_q  <= '0;
      wdata_a_q <= '0;
      wr_en_b_q <= 1'b0;
      addr_b_q  <= '0;
      wdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      nnz_q     <= nnz_d;
      pack_q    <= pack_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      wr_en_a_q <= wr_en_a_d;
      addr_a_q  <= addr_a_d;
      wdata_a_q <= wdata_a_d;
      wr_en_b_q <= wr_en_b_d;
      addr_b_q  <= addr_b_d;
      wdata_b_q <= wdata_b_d;
    end
  end

`ifdef SPMV_LOADER_CHECK_EN
  logic       error_q, error_d;
  logic [7:0] prev_q, prev_d;

  always_comb begin
    error_d = error_q;
    prev_d  = prev_q;
    if (state_q == S_IDLE && i_start) begin
      error_d = 1'b0;
    end else if (state_q == S_RP && accept) begin
      if (beat_q == 8'd0) begin
        if (i_data[7:0] != 8'd0) error_d = 1'b1;
      end else if (i_data[7:0] < prev_q) begin
        error_d = 1'b1;
      end
      prev_d = i_data[7:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      error_q <= 1'b0;
      prev_q  <= '0;
    end else begin
      error_q <= error_d;
      prev_q  <= prev_d;
    end
  end

  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  assign o_ready        = ready_q;
  assign o_wr_en_A      = wr_en_a_q;
  assign o_address_A    = addr_a_q;
  assign o_write_data_A = wdata_a_q;
  assign o_wr_en_B      = wr_en_b_q;
  assign o_address_B    = addr_b_q;
  assign o_write_data_B = wdata_b_q;
  assign o_state        = state_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_spmv_sram_loader.sv
// Randomized bench for spmv_sram_loader: expected SRAM lines are built from the CSR arrays directly.
module tb_spmv_sram_loader;

  localparam int MV_BASE     = 1;
  localparam int CI_BASE     = 1;
  localparam int RESULT_ADDR = 16;

`ifdef SPMV_LOADER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         valid;
  logic [15:0]  data;
  logic         o_ready;
  logic         wr_en_a;
  logic [4:0]   addr_a;
  logic [255:0] wdata_a;
  logic         wr_en_b;
  logic [4:0]   addr_b;
  logic [255:0] wdata_b;
  logic [2:0]   o_state;
  logic         o_error;
  logic         o_done;

  spmv_sram_loader #(
    .MV_BASE(MV_BASE), .CI_BASE(CI_BASE), .RESULT_ADDR(RESULT_ADDR)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .i_data(data),
    .o_ready(o_ready),
    .o_wr_en_A(wr_en_a), .o_address_A(addr_a), .o_write_data_A(wdata_a),
    .o_wr_en_B(wr_en_b), .o_address_B(addr_b), .o_write_data_B(wdata_b),
    .o_state(o_state), .o_error(o_error), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [260:0] exp_a[$], exp_b[$], act_a[$], act_b[$];
  int           done_cnt;
  logic         flush_at_done, err_at_done, res_hit;
  logic [2:0]   state_at_done;

  logic [15:0]  iv[16];
  logic [7:0]   rp[17];
  logic [15:0]  mv[256];
  logic [3:0]   ci[256];

  always @(negedge clk) begin
    if (wr_en_a) act_a.push_back({addr_a, wdata_a});
    if (wr_en_b) act_b.push_back({addr_b, wdata_b});
    if (wr_en_b && addr_b == 5'(RESULT_ADDR)) res_hit = 1'b1;
    if (o_done) begin
      done_cnt++;
      flush_at_done = wr_en_b;
      state_at_done = o_state;
      err_at_done   = o_error;
    end
  end

  task automatic chk(input string tag, input logic [260:0] got, input logic [260:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic int pick_gap(input int gap);
    return (gap >= 0) ? gap : int'($urandom_range(0, 2));
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input logic [15:0] d, input int gap);
    int waited;
    for (int g = 0; g < gap; g++) begin
      valid = 1'b0;
      @(negedge clk);
    end
    valid  = 1'b1;
    data   = d;
    waited = 0;
    while (!o_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!o_ready) chk("ready_timeout", 261'(o_ready), 261'(1));
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic build_expect(input int n);
    logic [255:0] line;
    exp_a.delete();
    exp_b.delete();
    line = '0;
    for (int k = 0; k < 16; k++) line[16*k +: 16] = iv[k];
    exp_a.push_back({5'd0, line});
    line = '0;
    for (int k = 0; k < 17; k++) line[8*k +: 8] = rp[k];
    exp_b.push_back({5'd0, line});
    for (int l = 0; l * 16 < n; l++) begin
      line = '0;
      for (int m = 0; m < 16; m++)
        if (l * 16 + m < n) line[16*m +: 16] = mv[l*16 + m];
      exp_a.push_back({5'(MV_BASE + l), line});
    end
    for (int l = 0; l * 64 < n; l++) begin
      line = '0;
      for (int m = 0; m < 64; m++)
        if (l * 64 + m < n) line[4*m +: 4] = ci[l*64 + m];
      exp_b.push_back({5'(CI_BASE + l), line});
    end
  endtask

  // mode 1: fixed patterns (iv = k+1, mv = 0x100+j, ci = j%16); mode 0: random words.
  task automatic run_load(input int n, input int mode, input int gap,
                          input int glitch_j, input int rst_j, input bit err_mode);
    bit exp_err;
    int n_a;
    for (int k = 0; k < 16; k++) iv[k] = (mode == 1) ? 16'(k + 1) : 16'($urandom);
    for (int k = 0; k < 17; k++) rp[k] = 8'((n * k) / 16);
    if (err_mode) begin
      rp[3] = 8'd5;
      rp[4] = 8'd4;
    end
    for (int j = 0; j < n; j++) begin
      mv[j] = (mode == 1) ? 16'(16'h0100 + j) : 16'($urandom);
      ci[j] = (mode == 1) ? 4'(j % 16) : 4'($urandom);
    end
    exp_err = 1'b0;
    if (CHECK_EN) begin
      if (rp[0] != 8'd0) exp_err = 1'b1;
      for (int k = 1; k < 17; k++) if (rp[k] < rp[k-1]) exp_err = 1'b1;
    end
    build_expect(n);
    act_a.delete();
    act_b.delete();
    done_cnt = 0;
    res_hit  = 1'b0;

    do_start();
    chk("start_err_clear", 261'(o_error), 261'(0));
    chk("start_state_iv", 261'({o_ready, o_state}), 261'({1'b1, 3'd1}));

    for (int k = 0; k < 16; k++) send(iv[k], pick_gap(gap));
    for (int k = 0; k < 17; k++) begin
      send({8'($urandom), rp[k]}, pick_gap(gap));
      if (err_mode && k == 3) chk("err_before_beat4", 261'(o_error), 261'(0));
      if (err_mode && k == 4) chk("err_after_beat4", 261'(o_error), 261'(exp_err));
    end
    for (int j = 0; j < n; j++) begin
      if (j == rst_j) begin
        valid = 1'b1;
        data  = mv[j];
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_a = act_a.size();
        chk("rst_ctrl_zero", 261'({o_ready, wr_en_a, addr_a, wr_en_b, addr_b, o_state, o_error, o_done}), 261'(0));
        chk("rst_data_a_zero", 261'(wdata_a), 261'(0));
        chk("rst_data_b_zero", 261'(wdata_b), 261'(0));
        repeat (3) @(negedge clk);
        chk("rst_no_a_write", 261'(act_a.size()), 261'(n_a));
        chk("rst_a_count", 261'(n_a), 261'(1));
        chk("rst_idle", 261'({o_ready, o_state}), 261'(0));
        valid = 1'b0;
        return;
      end
      if (j == glitch_j) start = 1'b1;
      send(mv[j], pick_gap(gap));
      start = 1'b0;
    end
    for (int j = 0; j < n; j++) send({12'($urandom), ci[j]}, pick_gap(gap));
    repeat (3) @(negedge clk);

    chk($sformatf("n%0d_a_count", n), 261'(act_a.size()), 261'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < act_a.size(); i++)
      chk($sformatf("n%0d_a_line%0d", n, i), act_a[i], exp_a[i]);
    chk($sformatf("n%0d_b_count", n), 261'(act_b.size()), 261'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < act_b.size(); i++)
      chk($sformatf("n%0d_b_line%0d", n, i), act_b[i], exp_b[i]);
    chk("done_once", 261'(done_cnt), 261'(1));
    chk("done_with_flush", 261'(flush_at_done), 261'(1));
    chk("done_state", 261'(state_at_done), 261'(5));
    chk("err_at_done", 261'(err_at_done), 261'(exp_err));
    chk("result_line_untouched", 261'(res_hit), 261'(0));
    chk("idle_after", 261'({o_ready, o_state, o_done}), 261'(0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_ctrl", 261'({o_ready, wr_en_a, addr_a, wr_en_b, addr_b, o_state, o_error, o_done}), 261'(0));
    chk("reset_data_a", 261'(wdata_a), 261'(0));
    chk("reset_data_b", 261'(wdata_b), 261'(0));

    run_load(0, 1, 0, -1, -1, 1'b0);
    run_load(20, 1, -1, -1, -1, 1'b0);
    run_load(255, 0, 3, -1, -1, 1'b0);
    run_load(20, 0, -1, 7, -1, 1'b1);
    run_load(37, 0, -1, -1, -1, 1'b0);
    for (int r = 0; r < 4; r++)
      run_load(int'($urandom_range(1, 255)), 0, -1, -1, -1, 1'b0);
    run_load(20, 0, 0, -1, 5, 1'b0);
    run_load(16, 0, 0, -1, -1, 1'b0);
    run_load(64, 0, -1, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
